periferico_bin2bcd: RTL and testbench



---
 rtl/calc_pkg.sv | 30 +++
 rtl/bcd_add3.sv | 11 +
 rtl/periferico_bin2bcd.sv | 115 +++++++++++
 tb/tb_periferico_bin2bcd.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator peripherals (register map, FSM encoding, widths).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package calc_pkg;

  localparam logic [4:0] ADDR_LO   = 5'h04;
  localparam logic [4:0] ADDR_HI   = 5'h08;
  localparam logic [4:0] ADDR_INIT = 5'h0C;
  localparam logic [4:0] ADDR_BCD  = 5'h10;
  localparam logic [4:0] ADDR_STAT = 5'h14;

  localparam int BIN_W  = 32;
  localparam int DIGITS = 10;
  localparam int BCD_W  = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Status word layout: digits 9..8 in [15:8], neg/busy/done in [2:0].
  function automatic logic [31:0] pack_status(input logic [7:0] hi_digits,
                                              input logic neg,
                                              input logic busy,
                                              input logic done);
    return {16'h0000, hi_digits, 5'b00000, neg, busy, done};
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit >= 5 becomes digit + 3.
// Latency: combinational.
// Backpressure: none.
module bcd_add3 (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/periferico_bin2bcd.sv
// Memory-mapped 32-bit binary to 10-digit BCD converter (sequential double-dabble); BIN2BCD_SIGNED_EN adds two's-complement input.
// Latency: INIT write at edge E -> busy from E, done and result readable after edge E+32.
// Backpressure: none; INIT writes while busy are dropped, operand writes while busy only touch the staging registers.
module periferico_bin2bcd
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  state_t               state, state_nxt;
  logic [15:0]          data_lo, data_hi;
  logic [BIN_W-1:0]     operand, snap, bin_sr;
  logic [BCD_W-1:0]     bcd_acc, bcd_adj, digits;
  logic [BCD_W+BIN_W-1:0] sr_next;
  logic [5:0]           cnt;
  logic                 wr_en, start, busy, done, neg;

  assign wr_en   = cs & wr;
  assign busy    = (state == SHIFT);
  assign done    = (state == DONE);
  assign start   = wr_en && (addr == ADDR_INIT) && d_in[0] && !busy;
  assign operand = {data_hi, data_lo};

`ifdef BIN2BCD_SIGNED_EN
  logic neg_run;
  // Negative operands are converted as their magnitude; 0x80000000 maps to 2^31.
  assign snap = operand[BIN_W-1] ? (~operand + 32'd1) : operand;
`else
  assign snap = operand;
  assign neg  = 1'b0;
`endif

  // One add-3 corrector per BCD digit, applied before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in  (bcd_acc[4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

  assign sr_next = {bcd_adj, bin_sr} << 1;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: start from IDLE/DONE, finish after the 32nd shift.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = SHIFT;
      SHIFT:      if (cnt == 6'd31) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Operand staging registers, conversion shift register and result latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_lo <= '0;
      data_hi <= '0;
      bin_sr  <= '0;
      bcd_acc <= '0;
      cnt     <= '0;
      digits  <= '0;
`ifdef BIN2BCD_SIGNED_EN
      neg_run <= 1'b0;
      neg     <= 1'b0;
`endif
    end else begin
      if (wr_en && addr == ADDR_LO) data_lo <= d_in;
      if (wr_en && addr == ADDR_HI) data_hi <= d_in;
      if (start) begin
        bin_sr  <= snap;
        bcd_acc <= '0;
        cnt     <= '0;
`ifdef BIN2BCD_SIGNED_EN
        neg_run <= operand[BIN_W-1];
`endif
      end else if (busy) begin
        bcd_acc <= sr_next[BCD_W+BIN_W-1:BIN_W];
        bin_sr  <= sr_next[BIN_W-1:0];
        cnt     <= cnt + 6'd1;
        if (cnt == 6'd31) begin
          digits <= sr_next[BCD_W+BIN_W-1:BIN_W];
`ifdef BIN2BCD_SIGNED_EN
          neg    <= neg_run;
`endif
        end
      end
    end
  end

  // Combinational read mux; idle bus and unmapped addresses read as zero.
  always_comb begin
    d_out = '0;
    if (cs && rd) begin
      case (addr)
        ADDR_BCD:  d_out = digits[31:0];
        ADDR_STAT: d_out = pack_status(digits[39:32], neg, busy, done);
        default:   d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_periferico_bin2bcd.sv
// Self-checking bench for periferico_bin2bcd; expected results queued at INIT, compared at done.
// Latency: checks the fixed 32-cycle conversion window.
// Backpressure: exercises INIT/operand writes while busy.
module tb_periferico_bin2bcd;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] d_in;
  logic        cs, rd, wr;
  logic [4:0]  addr;
  logic [31:0] d_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct packed {
    logic        neg;
    logic [39:0] bcd;
  } exp_t;

  exp_t sb[$];
  exp_t last_res = '0;

  periferico_bin2bcd dut (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits of the (possibly negated) operand.
  function automatic exp_t model(input logic [31:0] v);
    exp_t e;
    logic [31:0] m;
    m = v;
    e = '0;
`ifdef BIN2BCD_SIGNED_EN
    if (v[31]) begin
      m = -v;
      e.neg = 1'b1;
    end
`endif
    for (int i = 0; i < 10; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 32'd10);
      m = m / 32'd10;
    end
    return e;
  endfunction

  task automatic bus_write(input logic [4:0] a, input logic [15:0] dat);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = dat;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] v);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1;
    v = d_out;
    cs = 1'b0; rd = 1'b0;
    #1;
  endtask

  // Writes INIT=1, queues the expectation; c0 is the cycle count right after edge E.
  task automatic start_init(input exp_t e, output int c0);
    sb.push_back(e);
    bus_write(ADDR_INIT, 16'h0001);
    c0 = cyc;
  endtask

  task automatic start_conv(input logic [31:0] v, input exp_t e, output int c0);
    bus_write(ADDR_HI, v[31:16]);
    bus_write(ADDR_LO, v[15:0]);
    start_init(e, c0);
  endtask

  task automatic wait_and_check(input string name, input int c0);
    logic [31:0] s, v;
    exp_t e;
    bit seen;
    int overlap, lat;
    seen = 0; overlap = 0; lat = -1;
    for (int k = 0; k < 48; k++) begin
      bus_read(ADDR_STAT, s);
      if (s[0] && s[1]) overlap++;
      if (s[0]) begin
        seen = 1;
        lat = cyc - c0;
        break;
      end
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard_empty", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (!seen || lat !== 32) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, want 32 (done seen=%0d)", name, lat, seen);
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL %s busy_and_done: got %0d overlapping polls, want 0", name, overlap);
    end
    bus_read(ADDR_BCD, v);
    checks++;
    if (v !== e.bcd[31:0]) begin
      errors++;
      $display("FAIL %s digits: got %h, want %h", name, v, e.bcd[31:0]);
    end
    bus_read(ADDR_STAT, s);
    checks++;
    if (s !== {16'h0, e.bcd[39:32], 5'b0, e.neg, 2'b01}) begin
      errors++;
      $display("FAIL %s status: got %h, want %h", name, s, {16'h0, e.bcd[39:32], 5'b0, e.neg, 2'b01});
    end
    last_res = e;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (d_out !== 32'h0) begin
      errors++; $display("FAIL reset_dout: got %h, want 0", d_out);
    end
    reset = 1'b0;
    @(negedge clk);
    bus_read(ADDR_STAT, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL reset_status: got %h, want 0", v);
    end
    bus_read(ADDR_BCD, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL reset_digits: got %h, want 0", v);
    end
  endtask

  task automatic test_product();
    int c0;
    start_conv(32'h00053AFA, {1'b0, 40'h0000342778}, c0);
    wait_and_check("product_342778", c0);
  endtask

  task automatic test_max();
    int c0;
`ifdef BIN2BCD_SIGNED_EN
    start_conv(32'hFFFFFFFF, {1'b1, 40'h0000000001}, c0);
`else
    start_conv(32'hFFFFFFFF, {1'b0, 40'h4294967295}, c0);
`endif
    wait_and_check("all_ones", c0);
  endtask

  // Zero operand: busy (with old digits 9..8 still visible) for exactly 32 cycles.
  task automatic test_zero_timing();
    logic [31:0] s, want;
    int c0, bad;
    bad = 0;
    start_conv(32'h0, {1'b0, 40'h0}, c0);
    want = {16'h0, last_res.bcd[39:32], 5'b0, last_res.neg, 2'b10};
    for (int k = 0; k < 32; k++) begin
      bus_read(ADDR_STAT, s);
      if (s !== want) begin
        bad++;
        if (bad == 1) $display("FAIL busy_window at E+%0d: got %h, want %h", cyc - c0, s, want);
      end
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) errors++;
    wait_and_check("zero", c0);
  endtask

  // INIT and DATA_LO writes during a conversion do not disturb it.
  task automatic test_busy_writes();
    logic [31:0] s;
    int c0, c1;
    start_conv(32'd12345, {1'b0, 40'h0000012345}, c0);
    repeat (2) @(negedge clk);
    bus_write(ADDR_INIT, 16'h0001);
    bus_write(ADDR_LO, 16'h0009);
    bus_read(ADDR_STAT, s);
    checks++;
    if (s[1:0] !== 2'b10) begin
      errors++; $display("FAIL busy_after_init: got %b, want 10", s[1:0]);
    end
    wait_and_check("busy_writes", c0);
    // The staged DATA_LO write must have landed: next start converts 9.
    start_init({1'b0, 40'h0000000009}, c1);
    wait_and_check("staged_lo", c1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    exp_t dropped;
    int c0;
    start_conv(32'h00012345, model(32'h00012345), c0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #2;
    bus_read(ADDR_BCD, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL midreset_digits: got %h, want 0", v);
    end
    @(negedge clk);
    reset = 1'b0;
    dropped = sb.pop_back();
    if (dropped.neg) last_res = '0;
    last_res = '0;
    @(negedge clk);
    bus_read(ADDR_STAT, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL midreset_status: got %h, want 0", v);
    end
    // Only DATA_LO is written: DATA_HI must have been cleared by reset.
    bus_write(ADDR_LO, 16'd99);
    start_init({1'b0, 40'h0000000099}, c0);
    wait_and_check("after_reset_99", c0);
  endtask

  task automatic test_bus_rules();
    logic [31:0] v;
    int c0;
    start_conv(32'd987654321, {1'b0, 40'h0987654321}, c0);
    wait_and_check("bus_setup", c0);
    bus_write(ADDR_INIT, 16'h0000);
    bus_write(5'h18, 16'hFFFF);
    bus_read(ADDR_STAT, v);
    checks++;
    if (v !== 32'h00000901) begin
      errors++; $display("FAIL init_bit0_zero: got %h, want 00000901", v);
    end
    cs = 1'b1; rd = 1'b0; addr = ADDR_BCD;
    #1;
    checks++;
    if (d_out !== 32'h0) begin
      errors++; $display("FAIL read_strobe_low: got %h, want 0", d_out);
    end
    cs = 1'b0;
    #1;
    bus_read(ADDR_LO, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL read_write_only_reg: got %h, want 0", v);
    end
    bus_read(5'h1C, v);
    checks++;
    if (v !== 32'h0) begin
      errors++; $display("FAIL read_unmapped: got %h, want 0", v);
    end
  endtask

  task automatic test_random();
    logic [31:0] x;
    int c0;
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      start_conv(x, model(x), c0);
      wait_and_check("random", c0);
    end
  endtask

`ifdef BIN2BCD_SIGNED_EN
  task automatic test_signed();
    int c0;
    start_conv(32'h80000000, {1'b1, 40'h2147483648}, c0);
    wait_and_check("signed_min", c0);
    start_conv(32'hFFFFFFF6, {1'b1, 40'h0000000010}, c0);
    wait_and_check("signed_minus10", c0);
  endtask
`endif

  initial begin
    test_reset();
    test_product();
    test_max();
    test_zero_timing();
    test_busy_writes();
    test_reset_mid();
    test_bus_rules();
    test_random();
`ifdef BIN2BCD_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
